rv32_imm_enc: RTL
=================

Name: rv32_imm_enc

Overview:
- Instruction encoder: the inverse of the immediate decoder.
- Accepts an opcode, register fields and a decoded-form immediate, and packs them into a 32-bit RV32 instruction word.
- Flags immediates that cannot be represented in the selected format.
- Used by the debug/boot instruction injector to stream assembled words into instruction memory, so it carries a write-address counter and a 2-stage valid/ready pipeline.

Parameters:
- XPR_LEN, 32, instruction/immediate width.
- ADDR_W, 12, instruction-memory word-address width.
- CNT_W, 16, error-counter width.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  request accepted when in_valid && in_ready.
- in_opcode  input  7  opcode; also selects the format.
- in_rd  input  5  destination register.
- in_rs1  input  5  source register 1.
- in_rs2  input  5  source register 2.
- in_funct3  input  3  funct3 field.
- in_funct7  input  7  funct7 field; R-type only.
- in_csr  input  12  CSR address; SYSTEM only.
- in_imm  input  XPR_LEN  immediate in decoder convention.
- addr_load  input  1  load the write-address counter.
- addr_load_val  input  ADDR_W  value for the load.
- out_valid  output  1  encoded word valid.
- out_ready  input  1  consumer ready.
- out_instr  output  XPR_LEN  encoded instruction.
- out_addr  output  ADDR_W  target word address of out_instr.
- out_err  output  1  immediate not representable; valid with out_valid.
- err_cnt  output  CNT_W  saturating count of out_err handshakes.

Behaviour:
- Reset (async, rst_n=0): stage valids=0, out_valid=0, out_instr=0, out_err=0, out_addr=0, err_cnt=0. Reset mid-stream discards both stages; nothing is replayed.
- Pipeline: S1 registers the inputs, selects the format and computes the representability check. S2 packs the word into the output register.
  - advance = !out_valid || out_ready; in_ready = advance.
  - Both stages move together on advance.
  - Latency is 2 cycles from input handshake to out_valid; throughput is 1/cycle without stall.
  - While stalled, out_instr, out_addr and out_err hold stable.
- Format by opcode (bit fields of in_imm):
  - 1100111/0000011/0010011/0001111 (I): instr = {imm[11:0], rs1, f3, rd, op}. OK iff imm[31:11] all equal.
  - 1110011 (CSRI): instr = {csr, imm[4:0], f3, rd, op}. OK iff imm[31:4] all equal.
  - 0100011 (S): instr = {imm[11:5], rs2, rs1, f3, imm[4:0], op}. OK iff imm[31:11] all equal.
  - 1100011 (B): the immediate is the halfword offset (byte offset >> 1).
    - Bit mapping: instr[31]=imm[11], instr[7]=imm[10], instr[30:25]=imm[9:4], instr[11:8]=imm[3:0]; rs2, rs1, f3 and op in their usual fields.
    - OK iff imm[31:11] all equal.
  - 0110111/0010111 (U): instr = {imm[31:12], rd, op}. OK iff imm[11:0]==0.
  - 1101111 (J): the immediate is the halfword offset.
    - Bit mapping: instr[31]=imm[19], instr[30:21]=imm[9:0], instr[20]=imm[10], instr[19:12]=imm[18:11]; rd and op in their usual fields.
    - OK iff imm[31:19] all equal.
  - 0110011 (R): instr = {funct7, rs2, rs1, f3, rd, op}. in_imm is ignored; never an error.
  - Any other opcode: encoded as I-type with the I-type check.
- Round-trip rule: for every non-R opcode with OK=1, decoding out_instr yields in_imm exactly.
- Error: out_err = !OK. The word is still emitted using the truncated bits.
- err_cnt: increments on an out_valid && out_ready && out_err handshake and saturates at 2^CNT_W-1.
- Address counter:
  - out_addr is the address of the word currently in the output register.
  - It increments by 1 on each output handshake and wraps from 2^ADDR_W-1 to 0.
  - If addr_load and a handshake occur in the same cycle, addr_load wins: the next word gets addr_load_val, with no increment.
  - addr_load is legal at any time. A word stalled in the output register is retagged with addr_load_val.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1 -> out_valid=0, in_ready=1, out_addr=0, err_cnt=0. Release; the first word appears 2 cycles after the handshake.
- I/S round-trip:
  - op 0010011, rd=1, rs1=2, f3=0, imm=0xFFFFF800 -> out_instr=0x80010093, out_err=0.
  - op 0100011, rs1=2, rs2=3, f3=2, imm=0x7FF -> out_instr=0x7E312FA3.
- B/J/U edge cases:
  - B imm=0x800 -> out_err=1.
  - J imm=0xFFF80000 -> out_err=0, instr[31]=1.
  - U imm=0x12345001 -> out_err=1 and out_instr[31:12]=0x12345.
- Backpressure: stream 4 words with out_ready toggling 1,0,0,1.
  - Output values stay stable while stalled.
  - Words arrive in order with no loss or duplication.
  - in_ready=0 exactly when out_valid && !out_ready.
- Address: addr_load_val=0xFFE, then 3 handshakes -> out_addr 0xFFE, 0xFFF, 0x000. addr_load coincident with a handshake -> next word gets the loaded value.
- Counter/reset: with CNT_W overridden to 2, 5 error handshakes -> err_cnt saturates at 3. Assert rst_n low mid-stall -> all outputs cleared asynchronously and the pending word is dropped.

Source files
------------

// File: rtl/rv32_imm_enc.sv
// RV32 instruction encoder: packs opcode, register fields and a decoded-form
// immediate into a 32-bit instruction word. Flags immediates that do not fit
// the selected format. Two-stage valid/ready pipeline feeding an instruction
// memory writer, with a write-address counter and a saturating error counter.
module rv32_imm_enc #(
  parameter int XPR_LEN = 32,
  parameter int ADDR_W  = 12,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [6:0]         in_opcode,
  input  logic [4:0]         in_rd,
  input  logic [4:0]         in_rs1,
  input  logic [4:0]         in_rs2,
  input  logic [2:0]         in_funct3,
  input  logic [6:0]         in_funct7,
  input  logic [11:0]        in_csr,
  input  logic [XPR_LEN-1:0] in_imm,
  input  logic               addr_load,
  input  logic [ADDR_W-1:0]  addr_load_val,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XPR_LEN-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_addr,
  output logic               out_err,
  output logic [CNT_W-1:0]   err_cnt
);

  typedef enum logic [2:0] {
    FMT_I, FMT_CSRI, FMT_S, FMT_B, FMT_U, FMT_J, FMT_R
  } fmt_e;

  // True when bits [XPR_LEN-1:lsb] of v are all equal, i.e. v survives
  // truncation to lsb+1 bits followed by sign extension.
  function automatic logic sext_fits(input logic [XPR_LEN-1:0] v,
                                     input int unsigned lsb);
    logic signed [XPR_LEN-1:0] s;
    logic signed [XPR_LEN-1:0] sh;
    s  = v;
    sh = s >>> lsb;
    return (sh == '0) || (sh == '1);
  endfunction

  // Counter increment that sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // Field placement for each format; out-of-range immediates are truncated.
  function automatic logic [XPR_LEN-1:0] pack_word(
    input fmt_e               fmt,
    input logic [6:0]         op,
    input logic [4:0]         rd,
    input logic [4:0]         rs1,
    input logic [4:0]         rs2,
    input logic [2:0]         f3,
    input logic [6:0]         f7,
    input logic [11:0]        csr,
    input logic [XPR_LEN-1:0] imm
  );
    logic [XPR_LEN-1:0] w;
    case (fmt)
      FMT_CSRI: w = {csr, imm[4:0], f3, rd, op};
      FMT_S:    w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
      FMT_B:    w = {imm[11], imm[9:4], rs2, rs1, f3, imm[3:0], imm[10], op};
      FMT_U:    w = {imm[31:12], rd, op};
      FMT_J:    w = {imm[19], imm[9:0], imm[10], imm[18:11], rd, op};
      FMT_R:    w = {f7, rs2, rs1, f3, rd, op};
      default:  w = {imm[11:0], rs1, f3, rd, op};
    endcase
    return w;
  endfunction

  logic advance;
  logic out_hs;

  fmt_e fmt_d;
  logic ok_d;

  logic               vld_p1_q;
  fmt_e               fmt_p1_q;
  logic               ok_p1_q;
  logic [6:0]         op_p1_q;
  logic [4:0]         rd_p1_q;
  logic [4:0]         rs1_p1_q;
  logic [4:0]         rs2_p1_q;
  logic [2:0]         f3_p1_q;
  logic [6:0]         f7_p1_q;
  logic [11:0]        csr_p1_q;
  logic [XPR_LEN-1:0] imm_p1_q;

  logic [XPR_LEN-1:0] instr_d;
  logic               out_valid_q;
  logic [XPR_LEN-1:0] out_instr_q;
  logic               out_err_q;
  logic [ADDR_W-1:0]  out_addr_q;
  logic [ADDR_W-1:0]  addr_d;
  logic [CNT_W-1:0]   err_cnt_q;
  logic [CNT_W-1:0]   cnt_d;

  // Both stages shift together whenever the output slot is free or draining.
  assign advance  = !out_valid_q || out_ready;
  assign in_ready = advance;
  assign out_hs   = out_valid_q && out_ready;

  // ---- stage 0 -> 1: format select and representability check ----

  // Opcode selects the format; unknown opcodes fall back to I-type.
  always_comb begin
    fmt_d = FMT_I;
    case (in_opcode)
      7'b1100111, 7'b0000011, 7'b0010011, 7'b0001111: fmt_d = FMT_I;
      7'b1110011: fmt_d = FMT_CSRI;
      7'b0100011: fmt_d = FMT_S;
      7'b1100011: fmt_d = FMT_B;
      7'b0110111, 7'b0010111: fmt_d = FMT_U;
      7'b1101111: fmt_d = FMT_J;
      7'b0110011: fmt_d = FMT_R;
      default:    fmt_d = FMT_I;
    endcase
    ok_d = 1'b1;
    case (fmt_d)
      FMT_I, FMT_S, FMT_B: ok_d = sext_fits(in_imm, 11);
      FMT_CSRI:            ok_d = sext_fits(in_imm, 4);
      FMT_U:               ok_d = (in_imm[11:0] == 12'h000);
      FMT_J:               ok_d = sext_fits(in_imm, 19);
      default:             ok_d = 1'b1;
    endcase
  end

  // Stage-1 valid: the only control bit that needs reset in this stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q <= 1'b0;
    end else if (advance) begin
      vld_p1_q <= in_valid;
    end
  end

  // Stage-1 payload is qualified by vld_p1_q, so it is left unreset.
  always_ff @(posedge clk) begin
    if (advance && in_valid) begin
      fmt_p1_q <= fmt_d;
      ok_p1_q  <= ok_d;
      op_p1_q  <= in_opcode;
      rd_p1_q  <= in_rd;
      rs1_p1_q <= in_rs1;
      rs2_p1_q <= in_rs2;
      f3_p1_q  <= in_funct3;
      f7_p1_q  <= in_funct7;
      csr_p1_q <= in_csr;
      imm_p1_q <= in_imm;
    end
  end

  // ---- stage 1 -> 2: pack into the output register ----

  assign instr_d = pack_word(fmt_p1_q, op_p1_q, rd_p1_q, rs1_p1_q, rs2_p1_q,
                             f3_p1_q, f7_p1_q, csr_p1_q, imm_p1_q);

  // Output register holds its word while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_err_q   <= 1'b0;
    end else if (advance) begin
      out_valid_q <= vld_p1_q;
      if (vld_p1_q) begin
        out_instr_q <= instr_d;
        out_err_q   <= !ok_p1_q;
      end
    end
  end

  // Address follows the word in the output slot; a load overrides a step.
  always_comb begin
    addr_d = out_addr_q;
    if (addr_load) begin
      addr_d = addr_load_val;
    end else if (out_hs) begin
      addr_d = out_addr_q + 1'b1;
    end
    cnt_d = err_cnt_q;
    if (out_hs && out_err_q) begin
      cnt_d = sat_inc(err_cnt_q);
    end
  end

  // Address and error-counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_addr_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      out_addr_q <= addr_d;
      err_cnt_q  <= cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_err   = out_err_q;
  assign out_addr  = out_addr_q;
  assign err_cnt   = err_cnt_q;

endmodule
